regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the dual-issue core pipeline. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with write-to-read bypass and an optional hardwired zero register. An integrated pending-write scoreboard sets a busy bit at issue and clears it at writeback, and each read port reports whether its operand is still outstanding. It sits between decode/issue and the writeback stage, and feeds hazard/stall logic.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of architectural registers (power of 2, >=2)
NUM_RD, 4, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
rd_addr  in  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_pending  out  NUM_RD  operand p has an outstanding write not satisfied this cycle
wr_en  in  NUM_WR  write enable per write port
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_W  write data
alloc_en  in  NUM_WR  issue-time allocation: mark destination pending
alloc_addr  in  NUM_WR*AW  allocation destinations
flush  in  1  clear all pending bits (pipeline flush)
any_pending  out  1  OR of all pending bits

Behaviour:
- Reset: on a clk edge with rst=1, all registers become 0 and all pending bits become 0. Reset overrides every other input in that cycle, including in-flight writes and allocs. The outputs after reset are rd_data=0 (every port), rd_pending=0 and any_pending=0, until new writes/allocs arrive.
- Write: on a clk edge, for each w with wr_en[w]=1, reg[wr_addr[w]] <= wr_data[w]. If ZERO_REG=1 and the address is 0, the write is dropped.
- Same-cycle write collision (two ports, same address): the highest-index port wins in both storage and bypass.
- Read: zero-cycle latency. Per port p:
  - address 0 with ZERO_REG=1 -> 0.
  - else if any enabled write port targets the address this cycle -> that port's wr_data (highest-index match).
  - else -> stored value.
- Scoreboard: one pending bit per register. Next-state per register r, in priority order:
  1. rst -> 0.
  2. flush -> 0, and same-cycle allocs are ignored.
  3. any alloc_en[a] with alloc_addr[a]==r -> 1. A new producer wins over a same-cycle write to r.
  4. any wr_en[w] with wr_addr[w]==r -> 0.
  5. otherwise hold.
- Register 0 is never set pending when ZERO_REG=1.
- rd_pending[p] = pending[rd_addr[p]] AND NOT (a same-cycle enabled write to that address). The bypassed data is valid, so it is not reported as pending. It is 0 for address 0 when ZERO_REG=1.
- rd_pending does not reflect same-cycle allocs; those take effect from the next cycle.
- any_pending reflects registered pending state only (no bypass terms).
- Writes are never blocked by the scoreboard. A write to a non-pending register is legal and simply updates storage.
- flush does not affect register contents or same-cycle writes.
- Fully synchronous: no combinational path from rst to outputs except through state.

Test Plan:
- Reset/zero: assert rst for 2 cycles -> all rd_data=0, rd_pending=0, any_pending=0. Then write 0xDEADBEEF to r0 -> reads of r0 return 0 and r0 never goes pending.
- Write/bypass: wr_en[0], r5 <= 0x12345678, with rd_addr[0]=5 in the same cycle -> rd_data[0]=0x12345678 that cycle and every following cycle.
- Collision: port0 writes r7=0x1 and port1 writes r7=0x2 in the same cycle -> bypass reads 0x2, and the next cycle the stored value reads 0x2.
- Scoreboard: alloc r9 at cycle N.
  - Cycle N+1: rd_pending=1 for r9, any_pending=1.
  - Cycle N+3: write r9=0xA5 -> rd_pending=0 that cycle with data 0xA5.
  - Cycle N+4: any_pending=0.
- Alloc vs write: in the same cycle, write r3 and alloc r3 -> r3 is pending the next cycle and holds the written data.
- Flush/reset mid-operation:
  - alloc r4, r6, then flush together with alloc r8 -> all pending=0 the next cycle.
  - Write r10=0x55 together with rst=1 -> r10 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a pending-write
// scoreboard that flags operands whose producer has issued but not yet written back.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        alloc_en,
    input  logic [NUM_WR*AW-1:0]     alloc_addr,
    input  logic                     flush,
    output logic                     any_pending
);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pending;
    logic [DEPTH-1:0]  w_pendingNext;

    // Later loop iterations overwrite earlier ones, so the highest-index write port wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0)) begin
                    r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
            r_pending <= w_pendingNext;
        end
    end

    // Writebacks clear first, then allocations set, so a new producer beats a same-cycle writeback.
    always_comb begin
        w_pendingNext = r_pending;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                w_pendingNext[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        for (int a = 0; a < NUM_WR; a++) begin
            if (alloc_en[a]) begin
                w_pendingNext[alloc_addr[a*AW +: AW]] = 1'b1;
            end
        end
        if (flush) begin
            w_pendingNext = '0;
        end
        if (ZERO_REG != 0) begin
            w_pendingNext[0] = 1'b0;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_pend;
        logic              w_hit;

        assign w_addr = rd_addr[p*AW +: AW];

        // A same-cycle write supplies valid data, so a bypassed operand is never reported pending.
        always_comb begin
            w_hit  = 1'b0;
            w_data = r_regs[w_addr];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == w_addr) begin
                    w_hit  = 1'b1;
                    w_data = wr_data[w*DATA_W +: DATA_W];
                end
            end
            w_pend = r_pending[w_addr] & ~w_hit;
            if (ZERO_REG != 0 && w_addr == '0) begin
                w_data = '0;
                w_pend = 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = w_data;
        assign rd_pending[p]               = w_pend;
    end

    assign any_pending = |r_pending;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: a register/pending array model predicts
// every cycle's read outputs, and a separate monitor compares them against the DUT.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int AW     = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        alloc_en;
    logic [NUM_WR*AW-1:0]     alloc_addr;
    logic                     flush;
    logic                     any_pending;

    typedef struct {
        logic [NUM_RD*DATA_W-1:0] data;
        logic [NUM_RD-1:0]        pend;
        logic                     anyPend;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];

    logic [DATA_W-1:0] modelMem  [DEPTH];
    bit                modelPend [DEPTH];

    int compared   = 0;
    int mismatched = 0;

    regfile_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .flush(flush), .any_pending(any_pending)
    );

    always #5 clk = ~clk;

    // Reference read: r0 is zero, otherwise the last enabled write to the address, otherwise storage.
    function automatic void modelRead(input int a, output logic [DATA_W-1:0] d, output bit pd);
        bit hit = 0;
        d  = modelMem[a];
        pd = modelPend[a];
        if (a == 0) begin
            d  = '0;
            pd = 0;
            return;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
                d   = wr_data[w*DATA_W +: DATA_W];
                hit = 1;
            end
        end
        if (hit) pd = 0;
    endfunction

    function automatic bit modelAnyPend();
        bit r = 0;
        for (int i = 0; i < DEPTH; i++) r |= modelPend[i];
        return r;
    endfunction

    // Advance the model by one clock edge using the rule priorities: rst, flush, alloc, write, hold.
    function automatic void modelStep();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                modelMem[i]  = '0;
                modelPend[i] = 0;
            end
            return;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != 0)
                modelMem[wr_addr[w*AW +: AW]] = wr_data[w*DATA_W +: DATA_W];
        end
        for (int r = 0; r < DEPTH; r++) begin
            bit allocHit = 0;
            bit writeHit = 0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (alloc_en[k] && int'(alloc_addr[k*AW +: AW]) == r) allocHit = 1;
                if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == r) writeHit = 1;
            end
            if (flush || r == 0) modelPend[r] = 0;
            else if (allocHit)   modelPend[r] = 1;
            else if (writeHit)   modelPend[r] = 0;
        end
    endfunction

    task automatic clearInputs();
        rst = 0; flush = 0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = '0; alloc_addr = '0;
    endtask

    task automatic setRd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic setWr(input int w, input int a, input logic [DATA_W-1:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*AW +: AW] = AW'(a);
        wr_data[w*DATA_W +: DATA_W] = d;
    endtask

    task automatic setAlloc(input int k, input int a);
        alloc_en[k] = 1'b1;
        alloc_addr[k*AW +: AW] = AW'(a);
    endtask

    // Called just after a falling edge with inputs set; queues the prediction and steps the model.
    task automatic applyStimulus(input string tag, input bit doCheck);
        exp_t e;
        #1;
        if (doCheck) begin
            for (int p = 0; p < NUM_RD; p++) begin
                logic [DATA_W-1:0] d;
                bit pd;
                modelRead(int'(rd_addr[p*AW +: AW]), d, pd);
                e.data[p*DATA_W +: DATA_W] = d;
                e.pend[p] = pd;
            end
            e.anyPend = modelAnyPend();
            expQ.push_back(e);
            tagQ.push_back(tag);
        end
        @(posedge clk);
        modelStep();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        for (int p = 0; p < NUM_RD; p++) begin
            compared++;
            if (rd_data[p*DATA_W +: DATA_W] !== e.data[p*DATA_W +: DATA_W]) begin
                mismatched++;
                $display("[TB] FAIL %s rd_data[%0d] addr=%0d: got %h want %h", tag, p,
                         rd_addr[p*AW +: AW], rd_data[p*DATA_W +: DATA_W], e.data[p*DATA_W +: DATA_W]);
            end
            compared++;
            if (rd_pending[p] !== e.pend[p]) begin
                mismatched++;
                $display("[TB] FAIL %s rd_pending[%0d] addr=%0d: got %b want %b", tag, p,
                         rd_addr[p*AW +: AW], rd_pending[p], e.pend[p]);
            end
        end
        compared++;
        if (any_pending !== e.anyPend) begin
            mismatched++;
            $display("[TB] FAIL %s any_pending: got %b want %b", tag, any_pending, e.anyPend);
        end
    endtask

    // Monitor: compares the DUT outputs whenever a prediction has been queued.
    initial begin
        forever begin
            wait (expQ.size() > 0);
            checkOutput(expQ.pop_front(), tagQ.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i]  = '0;
            modelPend[i] = 0;
        end
        clearInputs();
        rd_addr = '0;
        @(negedge clk);

        // Reset and zero register
        rst = 1; applyStimulus("reset1", 0);
        rst = 1; applyStimulus("reset2", 1);
        for (int p = 0; p < NUM_RD; p++) setRd(p, p * 5);
        applyStimulus("postReset", 1);
        setWr(0, 0, 32'hDEADBEEF); setRd(0, 0); setAlloc(1, 0);
        applyStimulus("zeroWrite", 1);
        setRd(0, 0); applyStimulus("zeroRead", 1);

        // Write with same-cycle bypass, then stored value
        setWr(0, 5, 32'h12345678); setRd(0, 5);
        applyStimulus("bypass", 1);
        setRd(0, 5); applyStimulus("stored1", 1);
        setRd(0, 5); applyStimulus("stored2", 1);

        // Two-port collision
        setWr(0, 7, 32'h1); setWr(1, 7, 32'h2); setRd(1, 7);
        applyStimulus("collideBypass", 1);
        setRd(1, 7); applyStimulus("collideStored", 1);

        // Scoreboard alloc -> writeback
        setAlloc(0, 9); setRd(2, 9); applyStimulus("allocN", 1);
        setRd(2, 9); applyStimulus("allocN1", 1);
        setRd(2, 9); applyStimulus("allocN2", 1);
        setWr(1, 9, 32'hA5); setRd(2, 9); applyStimulus("wbN3", 1);
        setRd(2, 9); applyStimulus("wbN4", 1);

        // Alloc and write same register together
        setWr(0, 3, 32'hCAFE0003); setAlloc(0, 3); setRd(3, 3);
        applyStimulus("allocWrite", 1);
        setRd(3, 3); applyStimulus("allocWriteNext", 1);

        // Flush with a same-cycle alloc
        setAlloc(0, 4); setAlloc(1, 6); applyStimulus("alloc46", 1);
        setRd(0, 4); setRd(1, 6); setRd(2, 8);
        flush = 1; setAlloc(0, 8); applyStimulus("flush", 1);
        setRd(0, 4); setRd(1, 6); setRd(2, 8); setRd(3, 3);
        applyStimulus("postFlush", 1);

        // Reset beats a same-cycle write
        setWr(0, 10, 32'h55); setAlloc(1, 11); rst = 1; setRd(0, 10);
        applyStimulus("writeWithReset", 1);
        setRd(0, 10); setRd(1, 5); setRd(2, 11); applyStimulus("afterReset", 1);

        // Randomised traffic, addresses biased low to provoke collisions
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int w = 0; w < NUM_WR; w++) begin
                if ($urandom_range(0, 1) == 1)
                    setWr(w, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1),
                          $urandom());
                if ($urandom_range(0, 2) == 0)
                    setAlloc(w, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            end
            for (int p = 0; p < NUM_RD; p++)
                setRd(p, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            applyStimulus("random", 1);
        end

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        if (expQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d unchecked predictions want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
